mips_fetch_unit: RTL and testbench

MIPS_FETCH_UNIT -- requirements
Module: mips_fetch_unit

---
 rtl/mips_fetch_unit.sv | 125 ++++++++++++
 tb/tb_mips_fetch_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches, retires in-order responses into a
// {instr, pc} prefetch queue for decode; redirects flush the queue and orphan in-flight fetches.
module mips_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              id_valid,
  output logic [31:0]       id_instr,
  output logic [ADDR_W-1:0] id_pc,
  input  logic              id_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_req,
  output logic              halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_X = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {ST_RESET, ST_RUN, ST_DRAIN, ST_HALTED} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [CW-1:0]     count, live, stale, live_nxt, stale_nxt;
  logic [PW-1:0]     head, tail;
  logic [31:0]       instr_q [DEPTH];
  logic [ADDR_W-1:0] pc_q    [DEPTH];

  logic              accept, stale_ret, live_ret, push, pop;
  logic [CW:0]       occ_queue, occ_flight;
  logic [ADDR_W-1:0] rsp_addr;

  assign occ_queue  = {1'b0, count} + {1'b0, live};
  assign occ_flight = {1'b0, live} + {1'b0, stale};

  assign imem_req  = (state == ST_RUN) & ~redirect_valid & (occ_queue < DEPTH_X) & (occ_flight < DEPTH_X);
  assign imem_addr = pc;
  assign accept    = imem_req & imem_gnt;

  // Orphaned fetches drain first, so a response only belongs to the live stream once stale is empty.
  assign stale_ret = imem_rvalid & (stale != '0);
  assign live_ret  = imem_rvalid & (stale == '0) & (live != '0);
  // PC has advanced once per live request, so the oldest live fetch sits live words behind it.
  assign rsp_addr  = pc - ADDR_W'({live, 2'b00});

  assign push = live_ret & ~redirect_valid & (count != DEPTH_C);
  assign pop  = id_valid & id_ready;

  assign id_valid = (count != '0) & ~redirect_valid;
  assign id_instr = id_valid ? instr_q[head] : 32'h0;
  assign id_pc    = id_valid ? pc_q[head] : '0;
  assign halted   = (state == ST_HALTED);

  always_comb begin
    live_nxt  = live;
    stale_nxt = stale;
    if (redirect_valid) begin
      live_nxt  = '0;
      stale_nxt = stale + live - CW'(stale_ret) - CW'(live_ret);
    end else begin
      live_nxt  = live + CW'(accept) - CW'(live_ret);
      stale_nxt = stale - CW'(stale_ret);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RESET:  state_nxt = ST_RUN;
      ST_RUN:    if (halt_req) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (!halt_req)                                 state_nxt = ST_RUN;
        else if ((live_nxt == '0) && (stale_nxt == '0)) state_nxt = ST_HALTED;
      end
      ST_HALTED: if (!halt_req) state_nxt = ST_RUN;
      default:   state_nxt = ST_RESET;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_RESET;
      pc    <= RESET_PC;
      count <= '0;
      head  <= '0;
      tail  <= '0;
      live  <= '0;
      stale <= '0;
    end else begin
      state <= state_nxt;
      live  <= live_nxt;
      stale <= stale_nxt;
      if (redirect_valid) begin
        pc    <= redirect_pc & ~ADDR_W'(3);
        count <= '0;
        head  <= '0;
        tail  <= '0;
      end else begin
        if (accept) pc <= pc + ADDR_W'(4);
        if (push)   tail <= tail + PW'(1);
        if (pop)    head <= head + PW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (pop && !push) count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      instr_q[tail] <= imem_rdata;
      pc_q[tail]    <= rsp_addr;
    end
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: an in-order memory model with configurable latency
// feeds the fetch unit while each task drives one scenario and checks outputs inline.
module tb_mips_fetch_unit;

  logic        clock;
  logic        reset_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc;
  logic        redirect_valid, halt_req, halted;
  logic [31:0] redirect_pc;

  logic        imem_req8, imem_gnt8, imem_rvalid8, id_valid8, id_ready8;
  logic        redirect_valid8, halt_req8, halted8;
  logic [7:0]  imem_addr8, id_pc8, redirect_pc8;
  logic [31:0] imem_rdata8, id_instr8;

  mips_fetch_unit #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .halted(halted)
  );

  mips_fetch_unit #(.ADDR_W(8), .DEPTH(4), .RESET_PC(8'hF8)) dut8 (
    .clock(clock), .reset_n(reset_n),
    .imem_req(imem_req8), .imem_addr(imem_addr8), .imem_gnt(imem_gnt8),
    .imem_rvalid(imem_rvalid8), .imem_rdata(imem_rdata8),
    .id_valid(id_valid8), .id_instr(id_instr8), .id_pc(id_pc8), .id_ready(id_ready8),
    .redirect_valid(redirect_valid8), .redirect_pc(redirect_pc8),
    .halt_req(halt_req8), .halted(halted8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat      = 1;
  int req_cnt  = 0;
  int first_req_cyc = -1;

  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_instr[$];
  int          got_cyc[$];
  logic [7:0]  addr8_log[$];

  logic        s_req, s_idv, s_halted, s_rvld;
  logic [31:0] s_addr, s_idpc, s_instr;
  int          s_cyc;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h3C00_0000 ^ {a[15:0], a[15:0]};
  endfunction

  // One clock cycle: called at a falling edge, returns at the next falling edge.
  task automatic step();
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    #1;
    s_req = imem_req; s_addr = imem_addr; s_idv = id_valid; s_idpc = id_pc;
    s_instr = id_instr; s_halted = halted; s_rvld = imem_rvalid; s_cyc = cyc;
    if (imem_req && imem_gnt) begin
      if (req_cnt == 0) first_req_cyc = cyc;
      pend_addr.push_back(imem_addr);
      pend_due.push_back(cyc + lat);
      req_cnt++;
    end
    if (id_valid && id_ready) begin
      got_pc.push_back(id_pc);
      got_instr.push_back(id_instr);
      got_cyc.push_back(cyc);
    end
    if (imem_req8) addr8_log.push_back(imem_addr8);
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  task automatic flush_to(input logic [31:0] a);
    imem_gnt = 1'b0;
    repeat (8) step();
    redirect_valid = 1'b1;
    redirect_pc    = a;
    step();
    redirect_valid = 1'b0;
    got_pc.delete(); got_instr.delete(); got_cyc.delete();
    req_cnt = 0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (imem_req !== 1'b0)  begin n_fail++; $display("FAIL rst_req: got %0h want 0", imem_req); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %0h want 0", imem_addr); end
    n_checks++; if (id_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_idv: got %0h want 0", id_valid); end
    n_checks++; if (id_instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %0h want 0", id_instr); end
    n_checks++; if (id_pc !== 32'h0)    begin n_fail++; $display("FAIL rst_idpc: got %0h want 0", id_pc); end
    n_checks++; if (halted !== 1'b0)    begin n_fail++; $display("FAIL rst_halted: got %0h want 0", halted); end
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    step();
    n_checks++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL rst_first_cycle_req: got %0h want 0", s_req); end
  endtask

  task automatic test_streaming();
    imem_gnt = 1'b1; id_ready = 1'b1; lat = 1;
    repeat (12) step();
    n_checks++;
    if (got_pc.size() < 8) begin
      n_fail++; $display("FAIL stream_count: got %0d want >=8", got_pc.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++; if (got_pc[i] !== 32'(4*i)) begin n_fail++; $display("FAIL stream_pc[%0d]: got %0h want %0h", i, got_pc[i], 4*i); end
        n_checks++; if (got_instr[i] !== mem(got_pc[i])) begin n_fail++; $display("FAIL stream_instr[%0d]: got %0h want %0h", i, got_instr[i], mem(got_pc[i])); end
        n_checks++; if (got_cyc[i] !== first_req_cyc + 2 + i) begin n_fail++; $display("FAIL stream_cycle[%0d]: got %0d want %0d", i, got_cyc[i], first_req_cyc + 2 + i); end
      end
    end
  endtask

  task automatic test_stall();
    id_ready = 1'b0;
    flush_to(32'h200);
    imem_gnt = 1'b1; lat = 1;
    repeat (10) step();
    n_checks++; if (req_cnt !== 4)         begin n_fail++; $display("FAIL stall_reqs: got %0d want 4", req_cnt); end
    n_checks++; if (s_req !== 1'b0)        begin n_fail++; $display("FAIL stall_req_low: got %0h want 0", s_req); end
    n_checks++; if (s_idv !== 1'b1)        begin n_fail++; $display("FAIL stall_idv: got %0h want 1", s_idv); end
    n_checks++; if (s_idpc !== 32'h200)    begin n_fail++; $display("FAIL stall_head: got %0h want 200", s_idpc); end
    id_ready = 1'b1;
    repeat (8) step();
    n_checks++;
    if (got_pc.size() < 5) begin
      n_fail++; $display("FAIL stall_drain_count: got %0d want >=5", got_pc.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++; if (got_pc[i] !== 32'h200 + 32'(4*i)) begin n_fail++; $display("FAIL stall_drain_pc[%0d]: got %0h want %0h", i, got_pc[i], 32'h200 + 4*i); end
      end
      n_checks++; if (got_cyc[3] - got_cyc[0] !== 3) begin n_fail++; $display("FAIL stall_drain_rate: got %0d want 3", got_cyc[3] - got_cyc[0]); end
    end
  endtask

  task automatic test_redirect();
    id_ready = 1'b1;
    flush_to(32'h10);
    imem_gnt = 1'b1; lat = 3;
    step();
    step();
    n_checks++; if (req_cnt !== 2) begin n_fail++; $display("FAIL redir_outstanding: got %0d want 2", req_cnt); end
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    n_checks++; if (s_idv !== 1'b0) begin n_fail++; $display("FAIL redir_idv: got %0h want 0", s_idv); end
    n_checks++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL redir_req: got %0h want 0", s_req); end
    step();
    n_checks++; if (s_req !== 1'b1)      begin n_fail++; $display("FAIL redir_next_req: got %0h want 1", s_req); end
    n_checks++; if (s_addr !== 32'h100)  begin n_fail++; $display("FAIL redir_next_addr: got %0h want 100", s_addr); end
    repeat (8) step();
    n_checks++;
    if (got_pc.size() < 2) begin
      n_fail++; $display("FAIL redir_count: got %0d want >=2", got_pc.size());
    end else begin
      n_checks++; if (got_pc[0] !== 32'h100)         begin n_fail++; $display("FAIL redir_pc0: got %0h want 100", got_pc[0]); end
      n_checks++; if (got_instr[0] !== mem(32'h100)) begin n_fail++; $display("FAIL redir_instr0: got %0h want %0h", got_instr[0], mem(32'h100)); end
      n_checks++; if (got_pc[1] !== 32'h104)         begin n_fail++; $display("FAIL redir_pc1: got %0h want 104", got_pc[1]); end
    end
  endtask

  task automatic test_simultaneous();
    id_ready = 1'b0;
    flush_to(32'h40);
    imem_gnt = 1'b1; lat = 1;
    repeat (3) step();
    n_checks++; if (s_idv !== 1'b1) begin n_fail++; $display("FAIL simul_pre_idv: got %0h want 1", s_idv); end
    id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h302;
    step();
    redirect_valid = 1'b0;
    n_checks++; if (s_rvld !== 1'b1)     begin n_fail++; $display("FAIL simul_rsp_present: got %0h want 1", s_rvld); end
    n_checks++; if (s_idv !== 1'b0)      begin n_fail++; $display("FAIL simul_idv: got %0h want 0", s_idv); end
    n_checks++; if (got_pc.size() !== 0) begin n_fail++; $display("FAIL simul_pop: got %0d want 0", got_pc.size()); end
    step();
    n_checks++; if (s_idv !== 1'b0)      begin n_fail++; $display("FAIL simul_empty: got %0h want 0", s_idv); end
    n_checks++; if (s_addr !== 32'h300)  begin n_fail++; $display("FAIL simul_pc: got %0h want 300", s_addr); end
    repeat (4) step();
    n_checks++;
    if (got_pc.size() < 1) begin
      n_fail++; $display("FAIL simul_resume: got %0d want >=1", got_pc.size());
    end else if (got_pc[0] !== 32'h300) begin
      n_fail++; $display("FAIL simul_resume_pc: got %0h want 300", got_pc[0]);
    end
  endtask

  task automatic test_halt();
    int rise, last_rsp;
    id_ready = 1'b1; halt_req = 1'b0;
    flush_to(32'h80);
    imem_gnt = 1'b1; lat = 5;
    step();
    step();
    halt_req = 1'b1;
    step();
    rise = -1; last_rsp = -1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (s_rvld) last_rsp = s_cyc;
      if (s_halted && rise < 0) rise = s_cyc;
    end
    n_checks++; if (req_cnt !== 3) begin n_fail++; $display("FAIL halt_reqs: got %0d want 3", req_cnt); end
    n_checks++; if (rise < 0 || rise !== last_rsp + 1) begin n_fail++; $display("FAIL halt_rise: got %0d want %0d", rise, last_rsp + 1); end
    n_checks++;
    if (got_pc.size() !== 3) begin
      n_fail++; $display("FAIL halt_pops: got %0d want 3", got_pc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++; if (got_pc[i] !== 32'h80 + 32'(4*i)) begin n_fail++; $display("FAIL halt_pc[%0d]: got %0h want %0h", i, got_pc[i], 32'h80 + 4*i); end
      end
    end
    halt_req = 1'b0;
    step();
    n_checks++; if (s_halted !== 1'b1) begin n_fail++; $display("FAIL halt_hold: got %0h want 1", s_halted); end
    n_checks++; if (s_req !== 1'b0)    begin n_fail++; $display("FAIL halt_exit_req: got %0h want 0", s_req); end
    step();
    n_checks++; if (s_halted !== 1'b0)  begin n_fail++; $display("FAIL halt_clear: got %0h want 0", s_halted); end
    n_checks++; if (s_req !== 1'b1)     begin n_fail++; $display("FAIL halt_resume_req: got %0h want 1", s_req); end
    n_checks++; if (s_addr !== 32'h8C)  begin n_fail++; $display("FAIL halt_resume_addr: got %0h want 8c", s_addr); end
  endtask

  task automatic test_reset_midstream();
    id_ready = 1'b1;
    flush_to(32'h500);
    imem_gnt = 1'b1; lat = 1;
    repeat (5) step();
    n_checks++; if (s_idv !== 1'b1) begin n_fail++; $display("FAIL mid_pre_idv: got %0h want 1", s_idv); end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b0)    begin n_fail++; $display("FAIL mid_req: got %0h want 0", imem_req); end
    n_checks++; if (imem_addr !== 32'h0)  begin n_fail++; $display("FAIL mid_addr: got %0h want 0", imem_addr); end
    n_checks++; if (id_valid !== 1'b0)    begin n_fail++; $display("FAIL mid_idv: got %0h want 0", id_valid); end
    n_checks++; if (id_instr !== 32'h0)   begin n_fail++; $display("FAIL mid_instr: got %0h want 0", id_instr); end
    n_checks++; if (id_pc !== 32'h0)      begin n_fail++; $display("FAIL mid_idpc: got %0h want 0", id_pc); end
    n_checks++; if (imem_addr8 !== 8'hF8) begin n_fail++; $display("FAIL mid_addr8: got %0h want f8", imem_addr8); end
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    step();
    n_checks++; if (s_rvld !== 1'b1) begin n_fail++; $display("FAIL mid_stray_rsp: got %0h want 1", s_rvld); end
    n_checks++; if (s_req !== 1'b0)  begin n_fail++; $display("FAIL mid_reset_state_req: got %0h want 0", s_req); end
    step();
    n_checks++; if (s_req !== 1'b1 || s_addr !== 32'h0) begin n_fail++; $display("FAIL mid_restart: got req %0h addr %0h want req 1 addr 0", s_req, s_addr); end
    n_checks++; if (s_idv !== 1'b0) begin n_fail++; $display("FAIL mid_stray_dropped: got %0h want 0", s_idv); end
    step();
    n_checks++; if (s_idv !== 1'b0) begin n_fail++; $display("FAIL mid_fill_idv: got %0h want 0", s_idv); end
    step();
    n_checks++; if (s_idv !== 1'b1 || s_idpc !== 32'h0) begin n_fail++; $display("FAIL mid_first: got idv %0h pc %0h want idv 1 pc 0", s_idv, s_idpc); end
    n_checks++; if (s_instr !== mem(32'h0)) begin n_fail++; $display("FAIL mid_first_instr: got %0h want %0h", s_instr, mem(32'h0)); end
  endtask

  task automatic test_wrap8();
    n_checks++;
    if (addr8_log.size() < 3) begin
      n_fail++; $display("FAIL wrap_count: got %0d want >=3", addr8_log.size());
    end else begin
      n_checks++; if (addr8_log[0] !== 8'hF8) begin n_fail++; $display("FAIL wrap_a0: got %0h want f8", addr8_log[0]); end
      n_checks++; if (addr8_log[1] !== 8'hFC) begin n_fail++; $display("FAIL wrap_a1: got %0h want fc", addr8_log[1]); end
      n_checks++; if (addr8_log[2] !== 8'h00) begin n_fail++; $display("FAIL wrap_a2: got %0h want 00", addr8_log[2]); end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; halt_req = 1'b0;
    imem_gnt8 = 1'b1; imem_rvalid8 = 1'b0; imem_rdata8 = 32'h0; id_ready8 = 1'b1;
    redirect_valid8 = 1'b0; redirect_pc8 = 8'h0; halt_req8 = 1'b0;

    test_reset();
    test_streaming();
    test_stall();
    test_redirect();
    test_simultaneous();
    test_halt();
    test_wrap8();
    test_reset_midstream();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
